// File: rtl/muldiv_sequencer_pkg.sv
// Shared mul/div definitions: op and state encodings, widths, and the
// magnitude helper used at accept time.
package muldiv_sequencer_pkg;

  localparam int XLEN = 32;
  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One iteration on the 64-bit accumulator: shift-add for multiply (multiplier
// in the low half, shifted out LSB-first) or restoring shift-subtract for divide.
module muldiv_iter
  import muldiv_sequencer_pkg::*;
(
  input  logic                  is_div_i,
  input  logic [2*XLEN-1:0]     acc_i,
  input  logic [XLEN-1:0]       opb_i,
  output logic [2*XLEN-1:0]     acc_o
);

  logic [XLEN:0]   sum;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opb_i} : '0);
    // Shifted partial remainder is {acc[63], acc[62:31]}; the top bit alone means it exceeds any divisor.
    ge   = acc_i[2*XLEN-1] | (acc_i[2*XLEN-2:XLEN-1] >= opb_i);
    diff = acc_i[2*XLEN-2:XLEN-1] - opb_i;
    if (is_div_i)
      acc_o = ge ? {diff, acc_i[XLEN-2:0], 1'b1} : {acc_i[2*XLEN-2:0], 1'b0};
    else
      acc_o = {sum, acc_i[XLEN-1:1]};
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative 32-cycle mul/div unit for the EX stage: FSM, iteration counter,
// operand magnitude capture and final sign fixup around muldiv_iter.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            uns,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d;

  op_e               op_in;
  logic              accept, sa, sb, div_zero, div_ovf, last;
  logic [2*XLEN-1:0] iter_acc, prod_fix;
  logic [XLEN-1:0]   fixed;

  assign op_in    = op_e'(op);
  assign accept   = (state_q == S_IDLE) && start && !flush;
  assign last     = (cnt_q == 6'(ITER-1));
  // Plain mul yields the same low word either way, so it is always treated as signed.
  assign sa       = a[XLEN-1] && ((op_in == OP_MUL) || !uns);
  assign sb       = b[XLEN-1] && ((op_in == OP_MUL) || !uns);
  assign div_zero = op_in[1] && (b == '0);
  assign div_ovf  = op_in[1] && !uns && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  muldiv_iter u_iter (
    .is_div_i (op_q[1]),
    .acc_i    (acc_q),
    .opb_i    (opb_q),
    .acc_o    (iter_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (div_zero || div_ovf) ? S_DONE : S_BUSY;
      S_BUSY:  if (last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    stall  = accept || (state_q == S_BUSY);
    done   = (state_q == S_DONE);
    result = result_q;
  end

  always_comb begin
    prod_fix = neg_q ? (~iter_acc + 1'b1) : iter_acc;
    case (op_q)
      OP_MUL:  fixed = prod_fix[XLEN-1:0];
      OP_MULH: fixed = prod_fix[2*XLEN-1:XLEN];
      OP_DIV:  fixed = mag(iter_acc[XLEN-1:0], neg_q);
      default: fixed = mag(iter_acc[2*XLEN-1:XLEN], neg_q);
    endcase
  end

  always_comb begin
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (accept) begin
      op_d  = op_in;
      neg_d = (op_in == OP_REM) ? sa : (sa ^ sb);
      acc_d = {{XLEN{1'b0}}, mag(a, sa)};
      opb_d = mag(b, sb);
      cnt_d = '0;
      if (div_zero)     result_d = (op_in == OP_DIV) ? 32'hFFFF_FFFF : a;
      else if (div_ovf) result_d = (op_in == OP_DIV) ? 32'h8000_0000 : 32'h0;
    end else if ((state_q == S_BUSY) && !flush) begin
      acc_d = iter_acc;
      cnt_d = cnt_q + 6'd1;
      if (last) result_d = fixed;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed vector bench for muldiv_sequencer: table of ops with hand-computed
// results and latencies, plus flush / reset / flush-vs-start sequences.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, uns, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        stall, done;
  logic [31:0] result;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  op;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  muldiv_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .uns    (uns),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] o, input logic u, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] e, input int l);
    vec_t v;
    v.op = o; v.uns = u; v.a = x; v.b = y; v.exp = e; v.lat = l;
    vecs.push_back(v);
  endtask

  // Call just after a posedge; holds start through DONE like a stalled pipeline.
  task automatic run_op(input string nm, input vec_t v);
    int lat = 0, stl = 0;
    logic seen = 1'b0;
    start = 1'b1; op = v.op; uns = v.uns; a = v.a; b = v.b;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      if (stall) stl++;
      lat++;
      @(posedge clk); #1;
      a = $urandom; b = $urandom;
    end
    chk({nm, " done seen"}, 32'(seen), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'(v.lat));
    chk({nm, " stall cycles"}, 32'(stl), 32'(v.lat));
    chk({nm, " result"}, result, v.exp);
    chk({nm, " stall in DONE"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({nm, " single done pulse"}, 32'(done), 32'd0);
    chk({nm, " result held"}, result, v.exp);
    @(posedge clk); #1;
  endtask

  task automatic count_done(input string nm, input int cycles);
    int d = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) d++;
    end
    chk(nm, 32'(d), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    add(2'b00, 1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    add(2'b01, 1'b0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
    add(2'b01, 1'b1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
    add(2'b01, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    add(2'b10, 1'b0, 32'd100,        32'd7,         32'd14,        33);
    add(2'b11, 1'b0, 32'd100,        32'd7,         32'd2,         33);
    add(2'b10, 1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    add(2'b11, 1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    add(2'b10, 1'b1, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 33);
    add(2'b10, 1'b0, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    add(2'b11, 1'b0, 32'd5,          32'd0,         32'd5,         1);
    add(2'b10, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    add(2'b11, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
    add(2'b01, 1'b0, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);
    add(2'b11, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33);
    add(2'b00, 1'b1, 32'h1234_5678,  32'h10,        32'h2345_6780, 33);
    add(2'b10, 1'b0, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,        33);
    add(2'b11, 1'b0, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 33);

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; uns = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i]);

    // Flush on the 10th BUSY cycle.
    start = 1'b1; op = 2'b00; uns = 1'b0; a = 32'd3; b = 32'd5;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("flush busy stall", 32'(stall), 32'd1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush no done", 32'(done), 32'd0);
    chk("flush stall low", 32'(stall), 32'd0);
    chk("flush result kept", result, vecs[vecs.size()-1].exp);
    @(posedge clk); #1;
    v.op = 2'b00; v.uns = 1'b0; v.a = 32'd6; v.b = 32'd7; v.exp = 32'd42; v.lat = 33;
    run_op("after flush", v);
    count_done("flush late done", 36);

    // Flush and start in the same IDLE cycle accept nothing.
    start = 1'b1; flush = 1'b1; op = 2'b10; a = 32'd9; b = 32'd0;
    @(negedge clk);
    chk("flush+start stall", 32'(stall), 32'd0);
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    count_done("flush+start no accept", 36);
    chk("flush+start result kept", result, 32'd42);

    // Reset in BUSY.
    start = 1'b1; op = 2'b10; uns = 1'b0; a = 32'd100; b = 32'd7;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1; start = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst busy done", 32'(done), 32'd0);
    chk("rst busy stall", 32'(stall), 32'd0);
    chk("rst busy result", result, 32'd0);
    @(posedge clk); #1;
    count_done("rst no late done", 36);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
